// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage
// Brief    : MIPS execute stage with EX/MEM and WB operand forwarding, ALU,
//            destination select and the EX/MEM pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
module ex_stage #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_step,
    input  logic               i_flush,
    input  logic [NB_DATA-1:0] i_rs_data,
    input  logic [NB_DATA-1:0] i_rt_data,
    input  logic [NB_DATA-1:0] i_imm,
    input  logic [4:0]         i_shamt,
    input  logic [NB_REG-1:0]  i_rs,
    input  logic [NB_REG-1:0]  i_rt,
    input  logic [NB_REG-1:0]  i_rd,
    input  logic [3:0]         i_alu_op,
    input  logic               i_alu_src,
    input  logic               i_shift_var,
    input  logic               i_reg_dst,
    input  logic [1:0]         i_width,
    input  logic               i_sign_flag,
    input  logic               i_mem2reg,
    input  logic               i_memWrite,
    input  logic               i_regWrite,
    input  logic [NB_DATA-1:0] i_wb_data,
    input  logic [NB_REG-1:0]  i_wb_reg2write,
    input  logic               i_wb_regWrite,
    output logic [NB_DATA-1:0] o_result,
    output logic [NB_DATA-1:0] o_data4Mem,
    output logic [NB_REG-1:0]  o_reg2write,
    output logic [1:0]         o_width,
    output logic               o_sign_flag,
    output logic               o_mem2reg,
    output logic               o_memWrite,
    output logic               o_regWrite,
    output logic [1:0]         o_fwd_a,
    output logic [1:0]         o_fwd_b
);

    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_SUB  = 4'd1;
    localparam logic [3:0] c_OP_AND  = 4'd2;
    localparam logic [3:0] c_OP_OR   = 4'd3;
    localparam logic [3:0] c_OP_XOR  = 4'd4;
    localparam logic [3:0] c_OP_NOR  = 4'd5;
    localparam logic [3:0] c_OP_SLT  = 4'd6;
    localparam logic [3:0] c_OP_SLTU = 4'd7;
    localparam logic [3:0] c_OP_SLL  = 4'd8;
    localparam logic [3:0] c_OP_SRL  = 4'd9;
    localparam logic [3:0] c_OP_SRA  = 4'd10;
    localparam logic [3:0] c_OP_LUI  = 4'd11;

    localparam logic [1:0] c_FWD_NONE  = 2'b00;
    localparam logic [1:0] c_FWD_WB    = 2'b01;
    localparam logic [1:0] c_FWD_EXMEM = 2'b10;

    localparam logic [NB_REG-1:0] c_REG_ZERO = '0;

    logic [NB_DATA-1:0] r_result;
    logic [NB_DATA-1:0] r_data4Mem;
    logic [NB_REG-1:0]  r_reg2write;
    logic [1:0]         r_width;
    logic               r_sign_flag;
    logic               r_mem2reg;
    logic               r_memWrite;
    logic               r_regWrite;

    logic               w_exmem_hit_a;
    logic               w_exmem_hit_b;
    logic               w_wb_hit_a;
    logic               w_wb_hit_b;
    logic [1:0]         w_fwd_a;
    logic [1:0]         w_fwd_b;
    logic [NB_DATA-1:0] w_fwd_a_data;
    logic [NB_DATA-1:0] w_fwd_b_data;
    logic [NB_DATA-1:0] w_op_a;
    logic [NB_DATA-1:0] w_op_b;
    logic [4:0]         w_shamt;
    logic [NB_DATA-1:0] w_alu_result;
    logic [NB_REG-1:0]  w_dest;

    // Register 0 is hardwired to zero, so writes to it must never forward.
    assign w_exmem_hit_a = r_regWrite && (r_reg2write != c_REG_ZERO) && (r_reg2write == i_rs);
    assign w_exmem_hit_b = r_regWrite && (r_reg2write != c_REG_ZERO) && (r_reg2write == i_rt);
    assign w_wb_hit_a    = i_wb_regWrite && (i_wb_reg2write != c_REG_ZERO) && (i_wb_reg2write == i_rs);
    assign w_wb_hit_b    = i_wb_regWrite && (i_wb_reg2write != c_REG_ZERO) && (i_wb_reg2write == i_rt);

    // The EX/MEM result is the younger value and therefore takes priority.
    always_comb begin
        w_fwd_a      = c_FWD_NONE;
        w_fwd_a_data = i_rs_data;
        if (w_exmem_hit_a) begin
            w_fwd_a      = c_FWD_EXMEM;
            w_fwd_a_data = r_result;
        end else if (w_wb_hit_a) begin
            w_fwd_a      = c_FWD_WB;
            w_fwd_a_data = i_wb_data;
        end
    end

    always_comb begin
        w_fwd_b      = c_FWD_NONE;
        w_fwd_b_data = i_rt_data;
        if (w_exmem_hit_b) begin
            w_fwd_b      = c_FWD_EXMEM;
            w_fwd_b_data = r_result;
        end else if (w_wb_hit_b) begin
            w_fwd_b      = c_FWD_WB;
            w_fwd_b_data = i_wb_data;
        end
    end

    assign w_op_a  = w_fwd_a_data;
    assign w_op_b  = i_alu_src ? i_imm : w_fwd_b_data;
    assign w_shamt = i_shift_var ? w_fwd_a_data[4:0] : i_shamt;
    assign w_dest  = i_reg_dst ? i_rd : i_rt;

    always_comb begin
        w_alu_result = '0;
        case (i_alu_op)
            c_OP_ADD:  w_alu_result = w_op_a + w_op_b;
            c_OP_SUB:  w_alu_result = w_op_a - w_op_b;
            c_OP_AND:  w_alu_result = w_op_a & w_op_b;
            c_OP_OR:   w_alu_result = w_op_a | w_op_b;
            c_OP_XOR:  w_alu_result = w_op_a ^ w_op_b;
            c_OP_NOR:  w_alu_result = ~(w_op_a | w_op_b);
            c_OP_SLT:  w_alu_result = {{(NB_DATA-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
            c_OP_SLTU: w_alu_result = {{(NB_DATA-1){1'b0}}, (w_op_a < w_op_b)};
            c_OP_SLL:  w_alu_result = w_op_b << w_shamt;
            c_OP_SRL:  w_alu_result = w_op_b >> w_shamt;
            c_OP_SRA:  w_alu_result = $signed(w_op_b) >>> w_shamt;
            c_OP_LUI:  w_alu_result = {w_op_b[15:0], {(NB_DATA-16){1'b0}}};
            default:   w_alu_result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_result    <= '0;
            r_data4Mem  <= '0;
            r_reg2write <= '0;
            r_width     <= '0;
            r_sign_flag <= 1'b0;
            r_mem2reg   <= 1'b0;
            r_memWrite  <= 1'b0;
            r_regWrite  <= 1'b0;
        end else if (i_step) begin
            if (i_flush) begin
                r_result    <= '0;
                r_data4Mem  <= '0;
                r_reg2write <= '0;
                r_width     <= '0;
                r_sign_flag <= 1'b0;
                r_mem2reg   <= 1'b0;
                r_memWrite  <= 1'b0;
                r_regWrite  <= 1'b0;
            end else begin
                r_result    <= w_alu_result;
                r_data4Mem  <= w_fwd_b_data;
                r_reg2write <= w_dest;
                r_width     <= i_width;
                r_sign_flag <= i_sign_flag;
                r_mem2reg   <= i_mem2reg;
                r_memWrite  <= i_memWrite;
                r_regWrite  <= i_regWrite;
            end
        end
    end

    assign o_result    = r_result;
    assign o_data4Mem  = r_data4Mem;
    assign o_reg2write = r_reg2write;
    assign o_width     = r_width;
    assign o_sign_flag = r_sign_flag;
    assign o_mem2reg   = r_mem2reg;
    assign o_memWrite  = r_memWrite;
    assign o_regWrite  = r_regWrite;
    assign o_fwd_a     = w_fwd_a;
    assign o_fwd_b     = w_fwd_b;

endmodule
`default_nettype wire
